// File: rtl/jbi_rdata_pkg.sv
// Shared constants, write-FSM encoding and line-entry layout for the
// bank-2 return-data assembler.
package jbi_rdata_pkg;

    localparam int LINE_WORDS = 16;
    localparam int OUT_W      = 128;
    localparam int CTAG_W     = 16;
    localparam int LINE_BITS  = LINE_WORDS * 32;
    localparam int BEATS      = LINE_BITS / OUT_W;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_DROP
    } wstate_e;

    typedef struct packed {
        logic                 valid;
        logic [CTAG_W-1:0]    ctag;
        logic                 ue;
        logic [LINE_BITS-1:0] data;
    } line_entry_t;

    // Big-endian packing: word 0 occupies the most significant 32 bits of the line.
    function automatic int word_lsb(input logic [3:0] w);
        return LINE_BITS - 32 * (int'(w) + 1);
    endfunction

    function automatic int beat_lsb(input logic [1:0] b);
        return LINE_BITS - OUT_W * (int'(b) + 1);
    endfunction

endpackage

// File: rtl/jbi_sc2_rdata_asm_if.sv
// Bundles the scbuf input stream and the DMA return-beat handshake.
interface jbi_sc2_rdata_asm_if;
    import jbi_rdata_pkg::*;

    logic [31:0]       scbuf_jbi_data_d1;
    logic              scbuf_jbi_ctag_vld_d1;
    logic              scbuf_jbi_ue_err_d1;
    logic              rdata_vld;
    logic              rdata_rdy;
    logic [OUT_W-1:0]  rdata;
    logic [1:0]        rdata_beat;
    logic              rdata_last;
    logic [CTAG_W-1:0] rdata_ctag;
    logic              rdata_ue;
    logic              rdata_ovf;
    logic              rdata_proto_err;

    modport slave (
        input  scbuf_jbi_data_d1, scbuf_jbi_ctag_vld_d1, scbuf_jbi_ue_err_d1, rdata_rdy,
        output rdata_vld, rdata, rdata_beat, rdata_last, rdata_ctag, rdata_ue,
               rdata_ovf, rdata_proto_err
    );

    modport master (
        output scbuf_jbi_data_d1, scbuf_jbi_ctag_vld_d1, scbuf_jbi_ue_err_d1, rdata_rdy,
        input  rdata_vld, rdata, rdata_beat, rdata_last, rdata_ctag, rdata_ue,
               rdata_ovf, rdata_proto_err
    );

endinterface

// File: rtl/jbi_rdata_linebuf.sv
// Two-entry line storage: 32-bit word writes in, 128-bit beat reads out.
// Only the valid bits are reset; payload flops hold whatever was last written.
module jbi_rdata_linebuf
    import jbi_rdata_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hdr_en,
    input  logic [CTAG_W-1:0] i_hdr_ctag,
    input  logic              i_wr_en,
    input  logic              i_wr_entry,
    input  logic [3:0]        i_wr_word,
    input  logic [31:0]       i_wr_data,
    input  logic              i_wr_ue,
    input  logic              i_commit,
    input  logic              i_free,
    input  logic              i_rd_entry,
    input  logic [1:0]        i_rd_beat,
    output logic [1:0]        o_valid,
    output logic [OUT_W-1:0]  o_rd_data,
    output logic [CTAG_W-1:0] o_rd_ctag,
    output logic              o_rd_ue
);

    line_entry_t r_entry [2];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry[0].valid <= 1'b0;
            r_entry[1].valid <= 1'b0;
        end else begin
            if (i_free) begin
                r_entry[i_rd_entry].valid <= 1'b0;
            end
            if (i_commit) begin
                r_entry[i_wr_entry].valid <= 1'b1;
            end
            if (i_hdr_en) begin
                r_entry[i_wr_entry].ctag <= i_hdr_ctag;
                r_entry[i_wr_entry].ue   <= 1'b0;
            end
            if (i_wr_en) begin
                r_entry[i_wr_entry].data[word_lsb(i_wr_word) +: 32] <= i_wr_data;
                r_entry[i_wr_entry].ue <= r_entry[i_wr_entry].ue | i_wr_ue;
            end
        end
    end

    assign o_valid   = {r_entry[1].valid, r_entry[0].valid};
    assign o_rd_data = r_entry[i_rd_entry].data[beat_lsb(i_rd_beat) +: OUT_W];
    assign o_rd_ctag = r_entry[i_rd_entry].ctag;
    assign o_rd_ue   = r_entry[i_rd_entry].ue;

endmodule

// File: rtl/jbi_sc2_rdata_asm.sv
// Assembles ctag + 16-word packets from the unstallable scbuf stream into a
// two-entry line buffer and replays each line as four 128-bit beats.
module jbi_sc2_rdata_asm
    import jbi_rdata_pkg::*;
(
    input  logic                rclk,
    input  logic                rst,
    jbi_sc2_rdata_asm_if.slave  bus
);

    wstate_e           r_wstate, w_wstate_nxt;
    logic [3:0]        r_wcnt, w_wcnt_nxt;
    logic              r_wptr, w_wptr_nxt;
    logic              r_rptr;
    logic [1:0]        r_rcnt;
    logic              r_ovf, r_perr;

    logic              w_hdr_en, w_wr_en, w_commit, w_ovf, w_perr;
    logic [1:0]        w_valid;
    logic              w_vld, w_fire, w_free, w_can_accept;
    logic [OUT_W-1:0]  w_rd_data;
    logic [CTAG_W-1:0] w_rd_ctag;
    logic              w_rd_ue;

    jbi_rdata_linebuf u_linebuf (
        .i_clk      (rclk),
        .i_rst      (rst),
        .i_hdr_en   (w_hdr_en),
        .i_hdr_ctag (bus.scbuf_jbi_data_d1[CTAG_W-1:0]),
        .i_wr_en    (w_wr_en),
        .i_wr_entry (r_wptr),
        .i_wr_word  (r_wcnt),
        .i_wr_data  (bus.scbuf_jbi_data_d1),
        .i_wr_ue    (bus.scbuf_jbi_ue_err_d1),
        .i_commit   (w_commit),
        .i_free     (w_free),
        .i_rd_entry (r_rptr),
        .i_rd_beat  (r_rcnt),
        .o_valid    (w_valid),
        .o_rd_data  (w_rd_data),
        .o_rd_ctag  (w_rd_ctag),
        .o_rd_ue    (w_rd_ue)
    );

    assign w_vld  = w_valid[r_rptr];
    assign w_fire = w_vld & bus.rdata_rdy;
    assign w_free = w_fire & (r_rcnt == 2'(BEATS - 1));
    // With both entries full, wptr == rptr, so a last-beat free opens the very entry we need.
    assign w_can_accept = ~w_valid[r_wptr] | (w_free & (r_rptr == r_wptr));

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wcnt_nxt   = r_wcnt;
        w_wptr_nxt   = r_wptr;
        w_hdr_en     = 1'b0;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_ovf        = 1'b0;
        w_perr       = 1'b0;
        if (bus.scbuf_jbi_ctag_vld_d1) begin
            w_perr     = (r_wstate != W_IDLE);
            w_wcnt_nxt = '0;
            if (w_can_accept) begin
                w_hdr_en     = 1'b1;
                w_wstate_nxt = W_DATA;
            end else begin
                w_ovf        = 1'b1;
                w_wstate_nxt = W_DROP;
            end
        end else begin
            case (r_wstate)
                W_DATA: begin
                    w_wr_en    = 1'b1;
                    w_wcnt_nxt = r_wcnt + 4'd1;
                    if (r_wcnt == 4'(LINE_WORDS - 1)) begin
                        w_commit     = 1'b1;
                        w_wptr_nxt   = ~r_wptr;
                        w_wstate_nxt = W_IDLE;
                    end
                end
                W_DROP: begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                    if (r_wcnt == 4'(LINE_WORDS - 1)) begin
                        w_wstate_nxt = W_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_wcnt   <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_rcnt   <= '0;
            r_ovf    <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_wptr   <= w_wptr_nxt;
            r_ovf    <= w_ovf;
            r_perr   <= w_perr;
            if (w_fire) begin
                r_rcnt <= r_rcnt + 2'd1;
                if (w_free) begin
                    r_rptr <= ~r_rptr;
                end
            end
        end
    end

    assign bus.rdata_vld       = w_vld;
    assign bus.rdata           = w_rd_data;
    assign bus.rdata_beat      = r_rcnt;
    assign bus.rdata_last      = (r_rcnt == 2'(BEATS - 1));
    assign bus.rdata_ctag      = w_rd_ctag;
    assign bus.rdata_ue        = w_vld & w_rd_ue;
    assign bus.rdata_ovf       = r_ovf;
    assign bus.rdata_proto_err = r_perr;

endmodule

// File: tb/tb_jbi_sc2_rdata_asm.sv
// Directed bench for jbi_sc2_rdata_asm: expected beats go into a scoreboard
// queue at stimulus time and a negedge monitor pops them on every handshake.
module tb_jbi_sc2_rdata_asm;
    import jbi_rdata_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [1:0]   beat;
        logic [15:0]  ctag;
        logic         ue;
    } expBeat_t;

    logic rclk = 1'b0;
    logic rst;
    jbi_sc2_rdata_asm_if bus();

    jbi_sc2_rdata_asm dut (
        .rclk (rclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    int checks = 0;
    int failures = 0;
    int ovfCount = 0;
    int perrCount = 0;
    expBeat_t expQ[$];

    logic         stallValid = 1'b0;
    logic [127:0] heldData;
    logic [15:0]  heldCtag;
    logic         heldUe;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ctag, input logic [31:0] data, input logic ue);
        bus.scbuf_jbi_ctag_vld_d1 = ctag;
        bus.scbuf_jbi_data_d1     = data;
        bus.scbuf_jbi_ue_err_d1   = ue;
        @(posedge rclk);
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'h0BAD_F00D, 1'b0);
    endtask

    // Word w of a packet carries base + w.
    task automatic pushLine(input logic [15:0] ctag, input logic [31:0] base, input logic ue, input int nBeats);
        expBeat_t e;
        for (int b = 0; b < nBeats; b++) begin
            e.data = {base + 32'(4*b), base + 32'(4*b + 1), base + 32'(4*b + 2), base + 32'(4*b + 3)};
            e.beat = 2'(b);
            e.ctag = ctag;
            e.ue   = ue;
            expQ.push_back(e);
        end
    endtask

    task automatic sendPacket(input logic [15:0] ctag, input logic [31:0] base, input int ueWord, input logic hdrUe);
        applyStimulus(1'b1, {16'hDEAD, ctag}, hdrUe);
        for (int w = 0; w < 16; w++) begin
            applyStimulus(1'b0, base + 32'(w), (w == ueWord));
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        applyIdle();
        while (expQ.size() != 0 && n < 200) begin
            applyIdle();
            n++;
        end
        checkOutput({name, "Drained"}, 128'(expQ.size()), 128'd0);
        repeat (8) applyIdle();
    endtask

    always @(negedge rclk) begin
        expBeat_t e;
        if (rst) begin
            stallValid = 1'b0;
        end else begin
            if (bus.rdata_ovf) ovfCount++;
            if (bus.rdata_proto_err) perrCount++;
            if (bus.rdata_vld && stallValid) begin
                checkOutput("stallData", bus.rdata, heldData);
                checkOutput("stallCtag", bus.rdata_ctag, heldCtag);
                checkOutput("stallUe", bus.rdata_ue, heldUe);
            end
            if (bus.rdata_vld && !bus.rdata_rdy) begin
                stallValid = 1'b1;
                heldData   = bus.rdata;
                heldCtag   = bus.rdata_ctag;
                heldUe     = bus.rdata_ue;
            end else begin
                stallValid = 1'b0;
            end
            if (bus.rdata_vld && bus.rdata_rdy) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedBeat actual ctag=%0h beat=%0d expected none", bus.rdata_ctag, bus.rdata_beat);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beatData", bus.rdata, e.data);
                    checkOutput("beatIndex", bus.rdata_beat, e.beat);
                    checkOutput("beatLast", bus.rdata_last, (e.beat == 2'd3));
                    checkOutput("beatCtag", bus.rdata_ctag, e.ctag);
                    checkOutput("beatUe", bus.rdata_ue, e.ue);
                end
            end
        end
    end

    initial begin
        int ovfBase;
        int perrBase;
        rst = 1'b1;
        bus.rdata_rdy = 1'b0;
        bus.scbuf_jbi_ctag_vld_d1 = 1'b0;
        bus.scbuf_jbi_data_d1 = '0;
        bus.scbuf_jbi_ue_err_d1 = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        checkOutput("resetVld", bus.rdata_vld, 1'b0);
        checkOutput("resetOvf", bus.rdata_ovf, 1'b0);
        checkOutput("resetPerr", bus.rdata_proto_err, 1'b0);
        checkOutput("resetUe", bus.rdata_ue, 1'b0);
        checkOutput("resetBeat", bus.rdata_beat, 2'd0);
        rst = 1'b0;
        applyIdle();

        $display("[TB] single line");
        bus.rdata_rdy = 1'b1;
        pushLine(16'h1A2B, 32'h0, 1'b0, 4);
        applyStimulus(1'b1, {16'hDEAD, 16'h1A2B}, 1'b0);
        for (int w = 0; w < 15; w++) applyStimulus(1'b0, 32'(w), 1'b0);
        checkOutput("vldBeforeLastWord", bus.rdata_vld, 1'b0);
        applyStimulus(1'b0, 32'd15, 1'b0);
        checkOutput("vldAfterLastWord", bus.rdata_vld, 1'b1);
        checkOutput("beatAfterLastWord", bus.rdata_beat, 2'd0);
        repeat (3) applyIdle();
        checkOutput("vldOnBeat3", bus.rdata_vld, 1'b1);
        checkOutput("beat3Consecutive", bus.rdata_beat, 2'd3);
        applyIdle();
        checkOutput("vldAfterFourBeats", bus.rdata_vld, 1'b0);
        waitDrain("single");

        $display("[TB] ue capture");
        pushLine(16'h0C01, 32'h900, 1'b1, 4);
        pushLine(16'h0C02, 32'hA00, 1'b0, 4);
        pushLine(16'h0C03, 32'hB00, 1'b0, 4);
        sendPacket(16'h0C01, 32'h900, 9, 1'b0);
        sendPacket(16'h0C02, 32'hA00, -1, 1'b1);
        sendPacket(16'h0C03, 32'hB00, -1, 1'b0);
        waitDrain("ue");

        $display("[TB] back-pressure and ordering");
        bus.rdata_rdy = 1'b0;
        ovfBase = ovfCount;
        pushLine(16'h0001, 32'h1000, 1'b0, 4);
        pushLine(16'h0002, 32'h2000, 1'b0, 4);
        sendPacket(16'h0001, 32'h1000, -1, 1'b0);
        sendPacket(16'h0002, 32'h2000, -1, 1'b0);
        sendPacket(16'h0003, 32'h3000, -1, 1'b0);
        repeat (4) applyIdle();
        checkOutput("ovfPulseCount", 128'(ovfCount - ovfBase), 128'd1);
        bus.rdata_rdy = 1'b1;
        applyIdle();
        applyIdle();
        bus.rdata_rdy = 1'b0;
        repeat (3) applyIdle();
        bus.rdata_rdy = 1'b1;
        waitDrain("backpressure");

        $display("[TB] free on arrival");
        bus.rdata_rdy = 1'b0;
        ovfBase = ovfCount;
        pushLine(16'h0011, 32'h4100, 1'b0, 4);
        pushLine(16'h0022, 32'h4200, 1'b0, 4);
        pushLine(16'h0033, 32'h4300, 1'b0, 4);
        sendPacket(16'h0011, 32'h4100, -1, 1'b0);
        sendPacket(16'h0022, 32'h4200, -1, 1'b0);
        bus.rdata_rdy = 1'b1;
        repeat (3) applyIdle();
        checkOutput("beat3BeforeHeader", bus.rdata_beat, 2'd3);
        sendPacket(16'h0033, 32'h4300, -1, 1'b0);
        waitDrain("freeOnArrival");
        checkOutput("freeOnArrivalNoOvf", 128'(ovfCount - ovfBase), 128'd0);

        $display("[TB] protocol error");
        ovfBase = ovfCount;
        perrBase = perrCount;
        pushLine(16'hBBBB, 32'h5B00, 1'b0, 4);
        applyStimulus(1'b1, {16'hDEAD, 16'hAAAA}, 1'b0);
        for (int w = 0; w < 7; w++) applyStimulus(1'b0, 32'h5A00 + 32'(w), 1'b1);
        sendPacket(16'hBBBB, 32'h5B00, -1, 1'b0);
        waitDrain("protoErr");
        checkOutput("protoErrPulseCount", 128'(perrCount - perrBase), 128'd1);
        checkOutput("protoErrNoOvf", 128'(ovfCount - ovfBase), 128'd0);

        $display("[TB] reset mid-packet");
        bus.rdata_rdy = 1'b0;
        pushLine(16'h5555, 32'h6500, 1'b0, 2);
        sendPacket(16'h5555, 32'h6500, -1, 1'b0);
        bus.rdata_rdy = 1'b1;
        applyStimulus(1'b1, {16'hDEAD, 16'h6666}, 1'b0);
        applyStimulus(1'b0, 32'h6600, 1'b1);
        bus.rdata_rdy = 1'b0;
        for (int w = 1; w < 5; w++) applyStimulus(1'b0, 32'h6600 + 32'(w), 1'b1);
        checkOutput("beatBeforeReset", bus.rdata_beat, 2'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h6605, 1'b1);
        applyStimulus(1'b0, 32'h6606, 1'b1);
        checkOutput("rstVld", bus.rdata_vld, 1'b0);
        checkOutput("rstBeat", bus.rdata_beat, 2'd0);
        checkOutput("rstUe", bus.rdata_ue, 1'b0);
        checkOutput("rstOvf", bus.rdata_ovf, 1'b0);
        checkOutput("rstPerr", bus.rdata_proto_err, 1'b0);
        rst = 1'b0;
        for (int w = 7; w < 16; w++) applyStimulus(1'b0, 32'h6600 + 32'(w), 1'b0);
        checkOutput("strayWordsNoVld", bus.rdata_vld, 1'b0);
        bus.rdata_rdy = 1'b1;
        pushLine(16'h7777, 32'h7700, 1'b1, 4);
        sendPacket(16'h7777, 32'h7700, 3, 1'b0);
        waitDrain("reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
